cpu_bus_phase_ctrl: RTL
=======================

# cpu_bus_phase_ctrl

Parametrised 6809-family bus phase and halt controller for the main and sub CPU subsystems. Generates quadrature E/Q phases from the system clock by a programmable divider. Derives the read, write and Q·E bus strobes. Arbitrates halt requests from NREQ bus masters (main CPU, DMA, debugger) through a HALT/BA/BS handshake with timeout. It replaces the fixed-clock, single-halt-source glue around the CPU core.

## Interface
Parameters:
- DIV, 1: system clocks per E/Q quarter phase (≥1); one E period = 4·DIV clocks.
- NREQ, 2: number of halt requesters (1..8).
- TIMEOUT, 255: E cycles allowed for halt acknowledge before abort (1..65535).

Ports:
- SCPUCLK  in  1  sole clock; all state is updated on its rising edge.
- RESETBn  in  1  reset; synchronous, active-low.
- RnW  in  1  CPU read/not-write.
- BA  in  1  CPU bus available.
- BS  in  1  CPU bus status.
- HALTREQ  in  NREQ  level halt request, one bit per requester.
- E  out  1  E phase, registered.
- Q  out  1  Q phase, registered.
- E_FALL  out  1  one-clock pulse on the clock where E goes 1→0; used as the core clock enable.
- HALTn  out  1  halt to CPU core, registered.
- HALTGNT  out  NREQ  one-hot grant.
- TMO  out  1  one-clock pulse on halt-acknowledge timeout.
- HALTSTn  out  1  ~(BA & BS), combinational.
- QANDEn  out  1  ~(Q & E), combinational.
- WTQEn  out  1  QANDEn | RnW, combinational.
- RDQEn  out  1  ~((Q | E) & RnW), combinational.

## Operation
- Phase generator:
  - div counter runs 0..DIV-1; when it reaches DIV-1, the quarter index advances 0→1→2→3→0.
  - Outputs per quarter: q0 Q=1,E=0; q1 Q=1,E=1; q2 Q=0,E=1; q3 Q=0,E=0.
  - E_FALL=1 exactly on the first clock of q3.
- Halt FSM states: IDLE, REQ, HALTED, RELEASE. All transitions and HALTn changes occur only on E_FALL clocks, except where noted.
  - IDLE: if any HALTREQ is set, select a winner, latch its index, and clear HALTn. → REQ.
  - REQ:
    - Count E_FALLs.
    - If BA&BS=1: set HALTGNT[winner]=1. → HALTED.
    - Else if HALTREQ[winner]=0: set HALTn=1. → RELEASE.
    - Else if count reaches TIMEOUT: pulse TMO, set HALTn=1. → RELEASE.
  - HALTED: when HALTREQ[winner]=0, HALTGNT drops on the very next clock, not gated by E_FALL. Then HALTn=1 on the next E_FALL. → RELEASE.
  - RELEASE: when BA=0 on an E_FALL clock → IDLE. A new arbitration can start no earlier than the following E_FALL.
- HALTGNT is only ever asserted while BA&BS=1 is held. Request bits other than the winner's are ignored until IDLE.
- Arbitration is lowest-index-first unless the round-robin option below is compiled in.

## Timing
- Reset (RESETBn=0 sampled at a clock edge):
  - Phases: E=0, Q=0, E_FALL=0, div=0, quarter=3.
  - Halt: HALTn=1, HALTGNT=0, TMO=0, FSM=IDLE, timeout count=0, round-robin pointer=0.
- First Q rise occurs DIV clocks after reset release.
- Reset asserted mid-handshake forces all of the above on the same edge. Any grant drops immediately.
- Latencies:
  - HALTREQ rise → HALTn fall: ≤ 4·DIV clocks (next E_FALL).
  - BA&BS true at E_FALL → HALTGNT: 1 clock.
  - HALTREQ drop → HALTGNT drop: 1 clock.
- Timeout count width is ceil(log2(TIMEOUT+1)). It saturates and is cleared on entry to REQ.
- If a request and a timeout occur on the same E_FALL, the acknowledge (BA&BS=1) wins over the timeout.
- If the winner drops its request on the same E_FALL that BA&BS rises, the release path is taken and no grant is issued.
- DIV=1: E/Q period is 4 clocks and E_FALL is asserted every 4th clock.

## Configuration
- Macro HALT_ROUND_ROBIN_EN.
- Defined: a rotating priority pointer starts at index 0.
  - The winner is the first set HALTREQ bit at or above the pointer, wrapping modulo NREQ.
  - On entry to HALTED, the pointer becomes winner+1 mod NREQ.
  - A timeout or abort does not move the pointer.
- Undefined: fixed priority with index 0 highest, and no pointer register.

## Test plan
- DIV=2, free-run after reset:
  - Q rises at clock 2 and E at clock 4.
  - E_FALL pulses at clocks 8, 16, 24.
  - Q/E pattern repeats every 8 clocks.
- RnW=1, Q=1, E=1 → QANDEn=0, WTQEn=1, RDQEn=0. RnW=0 in the same phase → WTQEn=0, RDQEn=1.
- HALTREQ=2'b01, BA=BS=1 two E cycles later:
  - HALTn falls at the first E_FALL.
  - HALTGNT=01 one clock after the E_FALL that samples BA&BS.
  - Dropping the request clears HALTGNT next clock. HALTn rises at the next E_FALL.
  - FSM reaches IDLE after BA=0.
- TIMEOUT=3, BA held 0: TMO pulses once at the 3rd E_FALL after entering REQ. HALTn returns to 1 at that E_FALL. HALTGNT stays 0.
- HALTREQ=2'b11 held across three grants:
  - Fixed priority: grants are 01, 01, 01.
  - With HALT_ROUND_ROBIN_EN: grants are 01, 10, 01.
- RESETBn=0 pulsed for one clock while in HALTED: next clock shows HALTGNT=0, HALTn=1, E=Q=0, and the first Q rise is DIV clocks later.

Source files
------------

// File: rtl/cpu_bus_phase_ctrl_if.sv
// cpu_bus_phase_ctrl_if: CPU-side bus strobes and HALT/BA/BS handshake bundle.
// master = phase/halt controller, slave = CPU core and halt requesters.
interface cpu_bus_phase_ctrl_if #(
    parameter int NREQ = 2
);
    logic            RnW;
    logic            BA;
    logic            BS;
    logic [NREQ-1:0] HALTREQ;
    logic            E;
    logic            Q;
    logic            E_FALL;
    logic            HALTn;
    logic [NREQ-1:0] HALTGNT;
    logic            TMO;
    logic            HALTSTn;
    logic            QANDEn;
    logic            WTQEn;
    logic            RDQEn;

    modport master (
        input  RnW, BA, BS, HALTREQ,
        output E, Q, E_FALL, HALTn, HALTGNT, TMO, HALTSTn, QANDEn, WTQEn, RDQEn
    );

    modport slave (
        output RnW, BA, BS, HALTREQ,
        input  E, Q, E_FALL, HALTn, HALTGNT, TMO, HALTSTn, QANDEn, WTQEn, RDQEn
    );
endinterface

// File: rtl/cpu_bus_phase_ctrl.sv
// cpu_bus_phase_ctrl: E/Q quadrature generator, bus strobes and multi-source HALT arbiter.
// Define HALT_ROUND_ROBIN_EN for rotating halt priority; default is fixed (index 0 highest).
module cpu_bus_phase_ctrl #(
    parameter int DIV     = 1,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input logic                  SCPUCLK,
    input logic                  RESETBn,
    cpu_bus_phase_ctrl_if.master bus
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int WW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_HALTED = 2'd2, S_RELEASE = 2'd3;

    logic [DW-1:0]   div_q, div_d;
    logic [1:0]      qtr_q, qtr_d;
    logic            e_q, q_q, fall_q, step;
    logic [1:0]      st_q, st_d;
    logic [WW-1:0]   win_q, win_d, sel, base;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            halt_n_q, halt_n_d, tmo_q, tmo_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            req_w, ack;

    assign step  = div_q == DW'(DIV - 1);
    assign div_d = step ? '0 : div_q + 1'b1;
    assign qtr_d = step ? qtr_q + 2'd1 : qtr_q;
    assign req_w = bus.HALTREQ[win_q];
    assign ack   = bus.BA & bus.BS;

`ifdef HALT_ROUND_ROBIN_EN
    logic [WW-1:0] ptr_q, ptr_d;
    assign ptr_d = (st_q == S_REQ && st_d == S_HALTED) ? (win_q == WW'(NREQ - 1) ? '0 : win_q + 1'b1) : ptr_q;
    always_ff @(posedge SCPUCLK) begin
        ptr_q <= !RESETBn ? '0 : ptr_d;
    end
`endif

    // Scan from the highest offset down so the lowest offset from base wins.
    always_comb begin
`ifdef HALT_ROUND_ROBIN_EN
        base = ptr_q;
`else
        base = '0;
`endif
        sel = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.HALTREQ[WW'((int'(base) + i) % NREQ)]) sel = WW'((int'(base) + i) % NREQ);
        end
    end

    // The grant tracks the winner's request and BA&BS every clock; everything else waits for E_FALL.
    always_comb begin
        st_d     = st_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        halt_n_d = halt_n_q;
        gnt_d    = gnt_q;
        tmo_d    = 1'b0;
        if (st_q == S_HALTED && !(req_w && ack)) gnt_d = '0;
        if (fall_q) begin
            if (st_q == S_IDLE && |bus.HALTREQ) begin
                st_d     = S_REQ;
                win_d    = sel;
                cnt_d    = '0;
                halt_n_d = 1'b0;
            end else if (st_q == S_REQ) begin
                cnt_d = cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
                if (!req_w) begin
                    st_d     = S_RELEASE;
                    halt_n_d = 1'b1;
                end else if (ack) begin
                    st_d  = S_HALTED;
                    gnt_d = NREQ'(1) << win_q;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    st_d     = S_RELEASE;
                    halt_n_d = 1'b1;
                    tmo_d    = 1'b1;
                end
            end else if (st_q == S_HALTED && gnt_q == '0) begin
                st_d     = S_RELEASE;
                halt_n_d = 1'b1;
            end else if (st_q == S_RELEASE && !bus.BA) begin
                st_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge SCPUCLK) begin
        if (!RESETBn) begin
            div_q    <= '0;
            qtr_q    <= 2'd3;
            e_q      <= 1'b0;
            q_q      <= 1'b0;
            fall_q   <= 1'b0;
            st_q     <= S_IDLE;
            win_q    <= '0;
            cnt_q    <= '0;
            halt_n_q <= 1'b1;
            gnt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            qtr_q    <= qtr_d;
            e_q      <= qtr_d[0] ^ qtr_d[1];
            q_q      <= ~qtr_d[1];
            fall_q   <= step && qtr_d == 2'd3;
            st_q     <= st_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            halt_n_q <= halt_n_d;
            gnt_q    <= gnt_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.E       = e_q;
    assign bus.Q       = q_q;
    assign bus.E_FALL  = fall_q;
    assign bus.HALTn   = halt_n_q;
    assign bus.HALTGNT = gnt_q;
    assign bus.TMO     = tmo_q;
    assign bus.HALTSTn = ~ack;
    assign bus.QANDEn  = ~(q_q & e_q);
    assign bus.WTQEn   = ~(q_q & e_q) | bus.RnW;
    assign bus.RDQEn   = ~((q_q | e_q) & bus.RnW);
endmodule
